// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dm_pkg
//  Purpose  : Shared debug-module definitions: DMI op/status codes, APB
//             initiator FSM encoding and DM register addresses.
//  Revision : 1.0  initial release
// ============================================================================
package dm_pkg;

    // DMI operation codes carried on req_op
    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    // DMI response status codes carried on rsp_status
    localparam logic [1:0] ST_OK   = 2'd0;
    localparam logic [1:0] ST_FAIL = 2'd2;
    localparam logic [1:0] ST_BUSY = 2'd3;

    // APB initiator FSM states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } dmi_state_t;

    // DM register word addresses on the DMI
    localparam logic [6:0] DATA0      = 7'h04;
    localparam logic [6:0] DMCONTROL  = 7'h10;
    localparam logic [6:0] DMSTATUS   = 7'h11;
    localparam logic [6:0] HARTINFO   = 7'h12;
    localparam logic [6:0] ABSTRACTCS = 7'h16;
    localparam logic [6:0] COMMAND    = 7'h17;

    // True for ops that need an APB transfer
    function automatic logic op_is_bus(input logic [1:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmi_apb_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmi_apb_master_if
//  Purpose  : DMI request/response channel plus APB initiator bus of the
//             debug-module register path. 'master' is the initiator view,
//             'slave' is the DTM + APB target view.
//  Revision : 1.0  initial release
// ============================================================================
interface dmi_apb_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DMI_ABITS  = 7
);
    // DMI request
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [DMI_ABITS-1:0]  req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    // DMI response
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_status;
    logic [DATA_WIDTH-1:0] rsp_data;
    // APB
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  req_valid, req_op, req_addr, req_data, rsp_ready,
               prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_status, rsp_data,
               psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req_valid, req_op, req_addr, req_data, rsp_ready,
               prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_status, rsp_data,
               psel, penable, pwrite, paddr, pwdata
    );
endinterface
`default_nettype wire

// File: rtl/dmi_rsp_hold.sv
`default_nettype none
// ============================================================================
//  Module   : dmi_rsp_hold
//  Purpose  : One-entry DMI response register. Holds status/data stable with
//             rsp_valid until the DTM accepts it with rsp_ready.
//  Revision : 1.0  initial release
// ============================================================================
module dmi_rsp_hold #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  clock,
    input  wire logic                  reset,
    input  wire logic                  load,
    input  wire logic [1:0]            load_status,
    input  wire logic [DATA_WIDTH-1:0] load_data,
    input  wire logic                  rsp_ready,
    output logic                       rsp_valid,
    output logic [1:0]                 rsp_status,
    output logic [DATA_WIDTH-1:0]      rsp_data
);

    logic                  r_valid;
    logic [1:0]            r_status;
    logic [DATA_WIDTH-1:0] r_data;

    // Capture a new response on load; release valid once accepted
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_status <= 2'd0;
            r_data   <= '0;
        end else if (load) begin
            r_valid  <= 1'b1;
            r_status <= load_status;
            r_data   <= load_data;
        end else if (r_valid && rsp_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign rsp_valid  = r_valid;
    assign rsp_status = r_status;
    assign rsp_data   = r_data;

endmodule
`default_nettype wire

// File: rtl/dmi_apb_master.sv
`default_nettype none
// ============================================================================
//  Module   : dmi_apb_master
//  Purpose  : DMI-to-APB initiator for the debug-module register bus. One
//             SETUP/ACCESS transfer per DMI read/write, nop and reserved ops
//             answered locally, single outstanding transaction.
//  Options  : DMI_APB_TIMEOUT_EN - abort ACCESS with BUSY status after
//             TIMEOUT_CYCLES wait-state cycles.
//  Revision : 1.0  initial release
// ============================================================================
module dmi_apb_master
    import dm_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int DMI_ABITS      = 7,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic           clock,
    input  wire logic           reset,
    dmi_apb_master_if.master    bus
);

    dmi_state_t            r_state;
    dmi_state_t            w_state_nxt;
    logic                  w_accept;
    logic                  w_load;
    logic [1:0]            w_load_status;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic                  w_timeout;

    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;

    logic                  w_rsp_valid;
    logic [1:0]            w_rsp_status;
    logic [DATA_WIDTH-1:0] w_rsp_data;

`ifdef DMI_APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] r_wait_cnt;

    // Count ACCESS wait states; restart at every SETUP
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_SETUP) begin
            r_wait_cnt <= '0;
        end else if ((r_state == S_ACCESS) && !bus.pready) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_ACCESS) && !bus.pready &&
                       (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and response load selection
    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_load        = 1'b0;
        w_load_status = ST_OK;
        w_load_data   = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (op_is_bus(bus.req_op)) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_SETUP;
                    end else begin
                        // Nop answers OK, reserved op answers FAIL, no bus cycle
                        w_load        = 1'b1;
                        w_load_status = (bus.req_op == OP_NOP) ? ST_OK : ST_FAIL;
                        w_state_nxt   = S_RESP;
                    end
                end
            end
            S_SETUP: begin
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                if (bus.pready) begin
                    w_load        = 1'b1;
                    w_load_status = bus.pslverr ? ST_FAIL : ST_OK;
                    w_load_data   = r_pwrite ? '0 : bus.prdata;
                    w_state_nxt   = S_RESP;
                end else if (w_timeout) begin
                    w_load        = 1'b1;
                    w_load_status = ST_BUSY;
                    w_state_nxt   = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // APB address/data/direction: latched on accept, cleared when ACCESS ends
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
        end else if (w_accept) begin
            r_pwrite <= (bus.req_op == OP_WRITE);
            r_paddr  <= ADDR_WIDTH'(bus.req_addr);
            r_pwdata <= (bus.req_op == OP_WRITE) ? bus.req_data : '0;
        end else if ((r_state == S_ACCESS) && w_load) begin
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
        end
    end

    dmi_rsp_hold #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_hold (
        .clock       (clock),
        .reset       (reset),
        .load        (w_load),
        .load_status (w_load_status),
        .load_data   (w_load_data),
        .rsp_ready   (bus.rsp_ready),
        .rsp_valid   (w_rsp_valid),
        .rsp_status  (w_rsp_status),
        .rsp_data    (w_rsp_data)
    );

    // psel/penable decode straight from state so reset drops them on its edge
    assign bus.psel       = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign bus.penable    = (r_state == S_ACCESS);
    assign bus.pwrite     = r_pwrite;
    assign bus.paddr      = r_paddr;
    assign bus.pwdata     = r_pwdata;
    assign bus.req_ready  = (r_state == S_IDLE) && !reset;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_status = w_rsp_status;
    assign bus.rsp_data   = w_rsp_data;

endmodule
`default_nettype wire
